// File: rtl/gpio_cmd_pkg.sv
// Shared definitions for the GPIO command link: opcodes, word field positions
// and the responder FSM encoding.
package gpio_cmd_pkg;

    localparam int CMD_MSB     = 31;
    localparam int CMD_LSB     = 24;
    localparam int EN_BIT      = 23;
    localparam int PAYLOAD_MSB = 22;

    localparam logic [7:0] RESET       = 8'd0;
    localparam logic [7:0] EN_TX       = 8'd1;
    localparam logic [7:0] EN_RX       = 8'd2;
    localparam logic [7:0] PH_SEL      = 8'd3;
    localparam logic [7:0] RUN_MEM     = 8'd4;
    localparam logic [7:0] READ_MEM    = 8'd5;
    localparam logic [7:0] ADDR_MEM    = 8'd6;
    localparam logic [7:0] BER_S_I     = 8'd7;
    localparam logic [7:0] BER_S_Q     = 8'd8;
    localparam logic [7:0] BER_E_I     = 8'd9;
    localparam logic [7:0] BER_E_Q     = 8'd10;
    localparam logic [7:0] BER_H       = 8'd11;
    localparam logic [7:0] IS_MEM_FULL = 8'd12;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/gpio_strobe_edge.sv
// Enable-strobe register with a combinational rising-edge pulse; a level held
// high produces exactly one pulse.
module gpio_strobe_edge (
    input  logic clk,
    input  logic i_resetn,
    input  logic i_en,
    output logic o_rise
);

    logic en_q, en_d;

    always_comb begin
        en_d   = i_en;
        o_rise = i_en & ~en_q;
    end

    always_ff @(posedge clk or negedge i_resetn) begin
        if (!i_resetn) en_q <= 1'b0;
        else           en_q <= en_d;
    end

endmodule

// File: rtl/gpio_cmd_responder.sv
// Device end of the GPIO command link: captures a command on the strobe edge,
// executes it one clock later and drives registered controls / response word.
module gpio_cmd_responder
    import gpio_cmd_pkg::*;
#(
    parameter int NB_GPIOS        = 32,
    parameter int NB_CMD          = 8,
    parameter int NB_PHASE        = 2,
    parameter int BRAM_ADDR_WIDTH = 15,
    parameter int BRAM_DATA_WIDTH = 16,
    parameter int NB_BER_CNT      = 64,
    parameter int MEM_LAT         = 1
) (
    input  logic                       clk,
    input  logic                       i_resetn,
    input  logic [NB_GPIOS-1:0]        i_gpo,
    output logic [NB_GPIOS-1:0]        o_gpi,
    output logic                       o_rst,
    output logic                       o_enb_tx,
    output logic                       o_enb_rx,
    output logic [NB_PHASE-1:0]        o_phase_sel,
    output logic                       o_run_log,
    output logic                       o_read_log,
    output logic [BRAM_ADDR_WIDTH-1:0] o_addr_log,
    input  logic [BRAM_DATA_WIDTH-1:0] i_mem_data,
    input  logic                       i_mem_full,
    input  logic [NB_BER_CNT-1:0]      i_ber_samp_i,
    input  logic [NB_BER_CNT-1:0]      i_ber_samp_q,
    input  logic [NB_BER_CNT-1:0]      i_ber_err_i,
    input  logic [NB_BER_CNT-1:0]      i_ber_err_q
);

    logic                       rise;
    state_t                     state_q, state_d;
    logic [2:0]                 wait_q, wait_d;
    logic [NB_CMD-1:0]          op_q, op_d;
    logic [PAYLOAD_MSB:0]       pay_q, pay_d;
    logic                       rst_q, rst_d, tx_q, tx_d, rx_q, rx_d;
    logic [NB_PHASE-1:0]        ph_q, ph_d;
    logic                       run_q, run_d, rd_q, rd_d;
    logic [BRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [NB_GPIOS-1:0]        gpi_q, gpi_d, hi_q, hi_d;
    logic                       unused_pay;

    // Upper payload bits are carried for completeness; addresses wrap by truncation.
    assign unused_pay = ^pay_q[PAYLOAD_MSB:BRAM_ADDR_WIDTH];

    gpio_strobe_edge u_edge (
        .clk      (clk),
        .i_resetn (i_resetn),
        .i_en     (i_gpo[EN_BIT]),
        .o_rise   (rise)
    );

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        op_d    = op_q;
        pay_d   = pay_q;
        rst_d   = rst_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        ph_d    = ph_q;
        run_d   = 1'b0;
        rd_d    = rd_q;
        addr_d  = addr_q;
        gpi_d   = gpi_q;
        hi_d    = hi_q;
        unique case (state_q)
            ST_IDLE: if (rise) begin
                op_d    = i_gpo[CMD_MSB:CMD_LSB];
                pay_d   = i_gpo[PAYLOAD_MSB:0];
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_IDLE;
                case (op_q)
                    RESET:   rst_d = pay_q[0];
                    EN_TX:   tx_d  = pay_q[0];
                    EN_RX:   rx_d  = pay_q[0];
                    PH_SEL:  ph_d  = pay_q[NB_PHASE-1:0];
                    RUN_MEM: run_d = 1'b1;
                    READ_MEM, ADDR_MEM: begin
                        addr_d  = pay_q[BRAM_ADDR_WIDTH-1:0];
                        rd_d    = rd_q | (op_q == READ_MEM);
                        wait_d  = '0;
                        state_d = ST_MEM_WAIT;
                    end
                    // Latch both halves together so a later BER_H is coherent.
                    BER_S_I: {hi_d, gpi_d} = i_ber_samp_i[2*NB_GPIOS-1:0];
                    BER_S_Q: {hi_d, gpi_d} = i_ber_samp_q[2*NB_GPIOS-1:0];
                    BER_E_I: {hi_d, gpi_d} = i_ber_err_i[2*NB_GPIOS-1:0];
                    BER_E_Q: {hi_d, gpi_d} = i_ber_err_q[2*NB_GPIOS-1:0];
                    BER_H:       gpi_d = hi_q;
                    IS_MEM_FULL: gpi_d = NB_GPIOS'(i_mem_full);
                    default: ;
                endcase
            end
            ST_MEM_WAIT: begin
                if (wait_q == 3'(MEM_LAT - 1)) begin
                    gpi_d   = NB_GPIOS'(i_mem_data);
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            op_q    <= '0;
            pay_q   <= '0;
            rst_q   <= 1'b0;
            tx_q    <= 1'b0;
            rx_q    <= 1'b0;
            ph_q    <= '0;
            run_q   <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            gpi_q   <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            op_q    <= op_d;
            pay_q   <= pay_d;
            rst_q   <= rst_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            ph_q    <= ph_d;
            run_q   <= run_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            gpi_q   <= gpi_d;
            hi_q    <= hi_d;
        end
    end

    assign o_gpi       = gpi_q;
    assign o_rst       = rst_q;
    assign o_enb_tx    = tx_q;
    assign o_enb_rx    = rx_q;
    assign o_phase_sel = ph_q;
    assign o_run_log   = run_q;
    assign o_read_log  = rd_q;
    assign o_addr_log  = addr_q;

endmodule

// File: tb/tb_gpio_cmd_responder.sv
// Randomised command-level bench for gpio_cmd_responder with a timed
// behavioural model and a per-cycle output compare.
module tb_gpio_cmd_responder;
    import gpio_cmd_pkg::*;

    localparam int MEM_LAT = 1;

    logic        clk = 1'b0;
    logic        i_resetn;
    logic [31:0] i_gpo;
    logic [31:0] o_gpi;
    logic        o_rst, o_enb_tx, o_enb_rx, o_run_log, o_read_log;
    logic [1:0]  o_phase_sel;
    logic [14:0] o_addr_log;
    logic [15:0] i_mem_data;
    logic        i_mem_full;
    logic [63:0] i_ber_samp_i, i_ber_samp_q, i_ber_err_i, i_ber_err_q;

    always #5 clk = ~clk;

    gpio_cmd_responder #(.MEM_LAT(MEM_LAT)) dut (
        .clk          (clk),
        .i_resetn     (i_resetn),
        .i_gpo        (i_gpo),
        .o_gpi        (o_gpi),
        .o_rst        (o_rst),
        .o_enb_tx     (o_enb_tx),
        .o_enb_rx     (o_enb_rx),
        .o_phase_sel  (o_phase_sel),
        .o_run_log    (o_run_log),
        .o_read_log   (o_read_log),
        .o_addr_log   (o_addr_log),
        .i_mem_data   (i_mem_data),
        .i_mem_full   (i_mem_full),
        .i_ber_samp_i (i_ber_samp_i),
        .i_ber_samp_q (i_ber_samp_q),
        .i_ber_err_i  (i_ber_err_i),
        .i_ber_err_q  (i_ber_err_q)
    );

    // Log memory contents as a pure function of address.
    function automatic logic [15:0] mem_f(input logic [14:0] a);
        if (a == 15'h2A9C) return 16'hBEEF;
        return {a[7:0], ~a[14:7]} ^ 16'h5A3C;
    endfunction
    assign i_mem_data = mem_f(o_addr_log);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int kind; logic [31:0] val; } upd_t;
    upd_t pq[$];

    logic        e_rst, e_tx, e_rx, e_rd;
    logic [1:0]  e_ph;
    logic [14:0] e_addr;
    logic [31:0] e_gpi, m_hi;
    int          run_cyc = -10;
    int          busy_until = -1;
    bit          prev_stb = 1'b0;
    int          n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        pq.delete();
        e_rst = 0; e_tx = 0; e_rx = 0; e_rd = 0; e_ph = '0; e_addr = '0;
        e_gpi = '0; m_hi = '0; run_cyc = -10; busy_until = -1;
    endtask

    task automatic sched(input int c, input int k, input logic [31:0] v);
        upd_t u;
        u.cyc = c; u.kind = k; u.val = v;
        pq.push_back(u);
    endtask

    // Command accepted at cycle k: controls visible at k+2, memory data at k+2+MEM_LAT.
    task automatic accept(input logic [31:0] w);
        int k = cyc;
        logic [7:0]  op = w[31:24];
        logic [22:0] p  = w[22:0];
        busy_until = k + 1;
        case (op)
            RESET:   sched(k + 2, 0, 32'(p[0]));
            EN_TX:   sched(k + 2, 1, 32'(p[0]));
            EN_RX:   sched(k + 2, 2, 32'(p[0]));
            PH_SEL:  sched(k + 2, 3, 32'(p[1:0]));
            RUN_MEM: run_cyc = k + 2;
            READ_MEM, ADDR_MEM: begin
                sched(k + 2, 4, 32'(p[14:0]));
                if (op == READ_MEM) sched(k + 2, 5, 32'd1);
                sched(k + 2 + MEM_LAT, 6, 32'(mem_f(p[14:0])));
                busy_until = k + 1 + MEM_LAT;
            end
            BER_S_I: begin sched(k + 2, 6, i_ber_samp_i[31:0]); m_hi = i_ber_samp_i[63:32]; end
            BER_S_Q: begin sched(k + 2, 6, i_ber_samp_q[31:0]); m_hi = i_ber_samp_q[63:32]; end
            BER_E_I: begin sched(k + 2, 6, i_ber_err_i[31:0]);  m_hi = i_ber_err_i[63:32];  end
            BER_E_Q: begin sched(k + 2, 6, i_ber_err_q[31:0]);  m_hi = i_ber_err_q[63:32];  end
            BER_H:       sched(k + 2, 6, m_hi);
            IS_MEM_FULL: sched(k + 2, 6, 32'(i_mem_full));
            default: ;
        endcase
    endtask

    task automatic drive(input logic [31:0] w);
        @(posedge clk); #1;
        i_gpo = w;
        if (w[23] && !prev_stb && cyc > busy_until) accept(w);
        prev_stb = w[23];
    endtask

    task automatic issue(input logic [7:0] op, input logic [22:0] p, input int hold);
        for (int i = 0; i < hold; i++) drive({op, 1'b1, p});
        for (int i = 0; i < MEM_LAT + 3; i++) drive({op, 1'b0, p});
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        i_resetn = 1'b0;
        i_gpo = '0;
        prev_stb = 1'b0;
        model_clear();
        #1;
        chk("rst_gpi", o_gpi, 32'h0);
        chk("rst_ctl", {o_rst, o_enb_tx, o_enb_rx, o_run_log, o_read_log}, 32'h0);
        chk("rst_addr", o_addr_log, 32'h0);
        chk("rst_ph", o_phase_sel, 32'h0);
        repeat (2) @(posedge clk);
        #1 i_resetn = 1'b1;
    endtask

    always @(negedge clk) begin : cmp
        int i;
        i = 0;
        while (i < pq.size()) begin
            if (pq[i].cyc <= cyc) begin
                case (pq[i].kind)
                    0: e_rst  = pq[i].val[0];
                    1: e_tx   = pq[i].val[0];
                    2: e_rx   = pq[i].val[0];
                    3: e_ph   = pq[i].val[1:0];
                    4: e_addr = pq[i].val[14:0];
                    5: e_rd   = pq[i].val[0];
                    default: e_gpi = pq[i].val;
                endcase
                pq.delete(i);
            end else begin
                i++;
            end
        end
        chk("gpi", o_gpi, e_gpi);
        chk("rst", o_rst, e_rst);
        chk("enb_tx", o_enb_tx, e_tx);
        chk("enb_rx", o_enb_rx, e_rx);
        chk("phase_sel", o_phase_sel, e_ph);
        chk("run_log", o_run_log, (cyc == run_cyc));
        chk("read_log", o_read_log, e_rd);
        chk("addr_log", o_addr_log, e_addr);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: run did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] op;
        i_resetn = 1'b0;
        i_gpo = '0;
        i_mem_full = 1'b0;
        i_ber_samp_i = '0; i_ber_samp_q = '0; i_ber_err_i = '0; i_ber_err_q = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {o_gpi[30:0], o_rst, o_enb_tx, o_enb_rx, o_phase_sel,
                            o_run_log, o_read_log, o_addr_log} == '0, 32'h1);
        i_resetn = 1'b1;

        issue(EN_TX, 23'd1, 1);
        chk("tx_lit", o_enb_tx, 32'h1);
        issue(EN_RX, 23'd1, 2);
        chk("rx_lit", o_enb_rx, 32'h1);
        chk("rst_still0", o_rst, 32'h0);

        for (int i = 0; i < 4; i++) begin
            issue(PH_SEL, 23'(i), 1);
            chk("ph_lit", o_phase_sel, 32'(i));
        end
        // Level-held strobe with changing payload must update only once.
        drive({PH_SEL, 1'b1, 23'd1});
        for (int i = 0; i < 4; i++) drive({PH_SEL, 1'b1, 23'd2});
        for (int i = 0; i < MEM_LAT + 3; i++) drive({PH_SEL, 1'b0, 23'd2});
        chk("ph_hold_lit", o_phase_sel, 32'h1);

        i_ber_err_i = 64'h0000_0012_0000_0345;
        issue(BER_E_I, 23'd0, 1);
        chk("ber_lo_lit", o_gpi, 32'h0000_0345);
        i_ber_err_i = 64'h0000_0099_0000_0777;
        issue(BER_H, 23'd0, 1);
        chk("ber_hi_lit", o_gpi, 32'h0000_0012);

        issue(RUN_MEM, 23'd0, 3);
        i_mem_full = 1'b1;
        issue(IS_MEM_FULL, 23'd0, 1);
        chk("full_lit", o_gpi, 32'h1);

        // Second strobe lands in MEM_WAIT and must be dropped.
        drive({READ_MEM, 1'b1, 23'h2A9C});
        drive({READ_MEM, 1'b0, 23'h2A9C});
        drive({EN_TX, 1'b1, 23'h0});
        for (int i = 0; i < MEM_LAT + 3; i++) drive({EN_TX, 1'b0, 23'h0});
        chk("rd_addr_lit", o_addr_log, 32'h2A9C);
        chk("rd_en_lit", o_read_log, 32'h1);
        chk("rd_data_lit", o_gpi, 32'h0000_BEEF);
        chk("dropped_lit", o_enb_tx, 32'h1);

        issue(8'hFF, 23'h7F_FFFF, 1);
        chk("bad_op_lit", o_gpi, 32'h0000_BEEF);

        drive({READ_MEM, 1'b1, 23'h0123});
        drive({READ_MEM, 1'b0, 23'h0123});
        do_reset();

        for (int n = 0; n < 150; n++) begin
            i_ber_samp_i = {$urandom, $urandom};
            i_ber_samp_q = {$urandom, $urandom};
            i_ber_err_i  = {$urandom, $urandom};
            i_ber_err_q  = {$urandom, $urandom};
            i_mem_full   = 1'($urandom_range(0, 1));
            op = ($urandom_range(0, 15) < 13) ? 8'($urandom_range(0, 12))
                                              : 8'($urandom_range(13, 255));
            issue(op, 23'($urandom), $urandom_range(1, 5));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
